// File: rtl/mips_pkg.sv
// Shared definitions for the memory stage: FSM state encoding, abort data
// default and the word-alignment helper.
package mips_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } memState_e;

  localparam logic [31:0] ABORT_DATA_DEFAULT = 32'hDEADBEEF;
  localparam logic [31:0] WORD_ALIGN_MASK    = 32'h0000_0003;

  function automatic logic isWordAligned(input logic [31:0] addr);
    return (addr & WORD_ALIGN_MASK) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble retires the slot without a register
// write; data fields are still captured so an aborted load shows its data.
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubble,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic [31:0] ReadDataM,
  input  logic [31:0] ALUResultM,
  input  logic [4:0]  WriteRegM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [4:0]  WriteRegW
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWriteW  <= 1'b0;
      MemtoRegW  <= 1'b0;
      ReadDataW  <= '0;
      ALUResultW <= '0;
      WriteRegW  <= '0;
    end else begin
      RegWriteW  <= RegWriteM & ~bubble;
      MemtoRegW  <= MemtoRegM & ~bubble;
      ReadDataW  <= ReadDataM;
      ALUResultW <= ALUResultM;
      WriteRegW  <= WriteRegM;
    end
  end

endmodule

// File: rtl/memory_access_unit.sv
// M-stage data-memory access with request/ack handshake and pipeline stall.
// Define MEM_TIMEOUT_EN to abort accesses whose ack never arrives.
module memory_access_unit
  import mips_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ABORT_DATA     = ABORT_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic        BranchM,
  input  logic        ZeroFlagM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCBranch_ResultM,
  input  logic [4:0]  WriteRegM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        StallM,
  output logic        PCSrcM,
  output logic [31:0] PCBranchM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [4:0]  WriteRegW,
  output logic        mem_err
);

  memState_e   stateReg;
  logic        memOp;
  logic        access;
  logic        misaligned;
  logic        timeout;
  logic        bubble;
  logic [31:0] readDataIn;

  assign memOp      = MemtoRegM | MemWriteM;
  assign access     = memOp & isWordAligned(ALUResultM);
  assign misaligned = memOp & ~isWordAligned(ALUResultM);

  assign mem_req   = rst_n & access & ~timeout;
  assign mem_we    = mem_req & MemWriteM;
  assign mem_addr  = ALUResultM;
  assign mem_wdata = WriteDataM;
  assign StallM    = mem_req & ~mem_ack;
  assign PCSrcM    = rst_n & BranchM & ZeroFlagM & ~StallM;
  assign PCBranchM = PCBranch_ResultM;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] timeoutCount;

  always_ff @(posedge clk) begin
    if (!rst_n || stateReg == IDLE) begin
      timeoutCount <= '0;
    end else begin
      timeoutCount <= timeoutCount + 8'd1;
    end
  end

  assign timeout = (stateReg == WAIT) && (timeoutCount == 8'(TIMEOUT_CYCLES));
`else
  // No abort path: the parameter only keeps the interface identical.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  // A stalled, misaligned or aborted instruction leaves the pipe as a bubble.
  assign bubble     = StallM | misaligned | timeout;
  assign readDataIn = timeout ? ABORT_DATA : mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      mem_err  <= 1'b0;
    end else begin
      if (misaligned || timeout) begin
        mem_err <= 1'b1;
      end
      case (stateReg)
        IDLE: if (access && !mem_ack) stateReg <= WAIT;
        WAIT: if (!mem_req || mem_ack) stateReg <= IDLE;
        default: stateReg <= IDLE;
      endcase
    end
  end

  mem_wb_reg uMemWb (
    .clk        (clk),
    .rst_n      (rst_n),
    .bubble     (bubble),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .ReadDataM  (readDataIn),
    .ALUResultM (ALUResultM),
    .WriteRegM  (WriteRegM),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .ReadDataW  (ReadDataW),
    .ALUResultW (ALUResultW),
    .WriteRegW  (WriteRegW)
  );

endmodule

// File: tb/tb_memory_access_unit.sv
// Randomized bench for memory_access_unit against a transaction-level model.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroFlagM;
  logic [31:0] ALUResultM, WriteDataM, PCBranch_ResultM;
  logic [4:0]  WriteRegM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        StallM, PCSrcM;
  logic [31:0] PCBranchM;
  logic        RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, ALUResultW;
  logic [4:0]  WriteRegW;
  logic        mem_err;

  int   vectors     = 0;
  int   miscompares = 0;
  logic modelErr    = 1'b0;

  always #5 clk = ~clk;

  memory_access_unit #(
    .TIMEOUT_CYCLES (4),
    .ABORT_DATA     (32'hDEADBEEF)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .RegWriteM        (RegWriteM),
    .MemtoRegM        (MemtoRegM),
    .MemWriteM        (MemWriteM),
    .BranchM          (BranchM),
    .ZeroFlagM        (ZeroFlagM),
    .ALUResultM       (ALUResultM),
    .WriteDataM       (WriteDataM),
    .PCBranch_ResultM (PCBranch_ResultM),
    .WriteRegM        (WriteRegM),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_ack          (mem_ack),
    .StallM           (StallM),
    .PCSrcM           (PCSrcM),
    .PCBranchM        (PCBranchM),
    .RegWriteW        (RegWriteW),
    .MemtoRegW        (MemtoRegW),
    .ReadDataW        (ReadDataW),
    .ALUResultW       (ALUResultW),
    .WriteRegW        (WriteRegW),
    .mem_err          (mem_err)
  );

  task automatic checkValue(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic clearInputs();
    RegWriteM        = 1'b0;
    MemtoRegM        = 1'b0;
    MemWriteM        = 1'b0;
    BranchM          = 1'b0;
    ZeroFlagM        = 1'b0;
    ALUResultM       = '0;
    WriteDataM       = '0;
    PCBranch_ResultM = '0;
    WriteRegM        = '0;
    mem_rdata        = '0;
    mem_ack          = 1'b0;
  endtask

  // kind: 0 = ALU/branch, 1 = load, 2 = store. Called just after a rising edge.
  // An aligned access is acked 'delay' cycles after the request cycle.
  task automatic runTxn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic regWrite, input logic [4:0] wreg,
                        input logic branch, input logic zero, input logic [31:0] target,
                        input int delay, input logic strayAck, input logic [31:0] ackWord);
    logic        memOp, aligned, isAccess, expStall;
    logic [31:0] ackData;
    int          cycles;
    memOp    = (kind == 1) || (kind == 2);
    aligned  = (addr % 4) == 0;
    isAccess = memOp && aligned;
    cycles   = isAccess ? delay : 0;
    ackData  = '0;
    RegWriteM        = regWrite;
    MemtoRegM        = (kind == 1);
    MemWriteM        = (kind == 2);
    BranchM          = branch;
    ZeroFlagM        = zero;
    ALUResultM       = addr;
    WriteDataM       = wdata;
    PCBranch_ResultM = target;
    WriteRegM        = wreg;
    for (int c = 0; c <= cycles; c++) begin
      mem_ack   = isAccess ? (c == cycles) : strayAck;
      mem_rdata = (isAccess && c == cycles) ? ackWord : 32'($urandom);
      expStall  = isAccess && (c < cycles);
      @(negedge clk);
      checkValue("mem_req", 32'(mem_req), 32'(isAccess));
      checkValue("mem_we", 32'(mem_we), 32'(isAccess && kind == 2));
      checkValue("StallM", 32'(StallM), 32'(expStall));
      checkValue("PCSrcM", 32'(PCSrcM), 32'(branch && zero && !expStall));
      checkValue("PCBranchM", PCBranchM, target);
      if (isAccess) begin
        checkValue("mem_addr", mem_addr, addr);
        checkValue("mem_wdata", mem_wdata, wdata);
      end
      ackData = mem_rdata;
      @(posedge clk);
      #1;
      if (expStall) checkValue("RegWriteW_stall", 32'(RegWriteW), 32'd0);
    end
    if (memOp && !aligned) modelErr = 1'b1;
    checkValue("RegWriteW", 32'(RegWriteW), 32'(regWrite && !(memOp && !aligned)));
    checkValue("MemtoRegW", 32'(MemtoRegW), 32'(kind == 1 && aligned));
    checkValue("ALUResultW", ALUResultW, addr);
    checkValue("WriteRegW", 32'(WriteRegW), 32'(wreg));
    checkValue("ReadDataW", ReadDataW, ackData);
    checkValue("mem_err", 32'(mem_err), 32'(modelErr));
    $display("txn kind=%0d addr=%08h delay=%0d regWrite=%0b ReadDataW=%08h mem_err=%0b",
             kind, addr, cycles, RegWriteW, ReadDataW, mem_err);
  endtask

  int          rKind, rDelay;
  logic [31:0] rAddr, rData, rTarget, rAck;
  logic [4:0]  rReg;
  logic        rRegWrite, rBranch, rZero, rStray;

  initial begin
    clearInputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset_RegWriteW", 32'(RegWriteW), 32'd0);
    checkValue("reset_ReadDataW", ReadDataW, 32'd0);
    checkValue("reset_ALUResultW", ALUResultW, 32'd0);
    checkValue("reset_mem_err", 32'(mem_err), 32'd0);
    checkValue("reset_mem_req", 32'(mem_req), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load with ack three cycles after the request.
    runTxn(1, 32'h100, 32'h0, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0, 3, 1'b0, 32'h12345678);
    // Zero-wait store.
    runTxn(2, 32'h104, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    // Branch taken and not taken.
    runTxn(0, 32'h8, 32'h0, 1'b1, 5'd7, 1'b1, 1'b1, 32'h40, 0, 1'b0, 32'h0);
    runTxn(0, 32'h0, 32'h0, 1'b1, 5'd7, 1'b1, 1'b0, 32'h40, 0, 1'b0, 32'h0);
    // Ack with no request is ignored.
    runTxn(0, 32'h55, 32'h0, 1'b1, 5'd9, 1'b0, 1'b0, 32'h0, 0, 1'b1, 32'h0);
    // Misaligned load.
    runTxn(1, 32'h102, 32'h0, 1'b1, 5'd4, 1'b0, 1'b0, 32'h0, 2, 1'b0, 32'h0);

    // Reset pulse while the access is waiting.
    RegWriteM  = 1'b1;
    MemtoRegM  = 1'b1;
    ALUResultM = 32'h200;
    WriteRegM  = 5'd12;
    BranchM    = 1'b1;
    ZeroFlagM  = 1'b1;
    mem_ack    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkValue("wait_StallM", 32'(StallM), 32'd1);
    rst_n = 1'b0;
    #1;
    checkValue("rst_mem_req", 32'(mem_req), 32'd0);
    checkValue("rst_StallM", 32'(StallM), 32'd0);
    checkValue("rst_PCSrcM", 32'(PCSrcM), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clearInputs();
    #1;
    modelErr = 1'b0;
    checkValue("post_rst_mem_req", 32'(mem_req), 32'd0);
    checkValue("post_rst_StallM", 32'(StallM), 32'd0);
    checkValue("post_rst_RegWriteW", 32'(RegWriteW), 32'd0);
    checkValue("post_rst_WriteRegW", 32'(WriteRegW), 32'd0);
    checkValue("post_rst_ALUResultW", ALUResultW, 32'd0);
    checkValue("post_rst_mem_err", 32'(mem_err), 32'd0);
    @(posedge clk);
    #1;
    // A zero-wait load right after reset must not stall (FSM back in IDLE).
    runTxn(1, 32'h204, 32'h0, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'hA5A5_0001);

`ifdef MEM_TIMEOUT_EN
    // No ack: request cycle plus four WAIT cycles, then the abort cycle.
    RegWriteM  = 1'b1;
    MemtoRegM  = 1'b1;
    MemWriteM  = 1'b0;
    ALUResultM = 32'h300;
    WriteRegM  = 5'd6;
    mem_ack    = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      checkValue("to_mem_req", 32'(mem_req), 32'(c < 5));
      checkValue("to_StallM", 32'(StallM), 32'(c < 5));
      @(posedge clk);
      #1;
    end
    modelErr = 1'b1;
    checkValue("to_RegWriteW", 32'(RegWriteW), 32'd0);
    checkValue("to_ReadDataW", ReadDataW, 32'hDEADBEEF);
    checkValue("to_mem_err", 32'(mem_err), 32'd1);
    $display("txn timeout abort ReadDataW=%08h mem_err=%0b", ReadDataW, mem_err);
`endif

    for (int t = 0; t < 300; t++) begin
      rKind     = int'($urandom_range(0, 2));
      rAddr     = $urandom;
      if ($urandom_range(0, 3) != 0) rAddr[1:0] = 2'b00;
      rData     = $urandom;
      rTarget   = $urandom;
      rAck      = $urandom;
      rReg      = 5'($urandom);
      rRegWrite = (rKind == 1) ? 1'b1 : (rKind == 2) ? 1'b0 : 1'($urandom);
      rBranch   = 1'($urandom);
      rZero     = 1'($urandom);
      rStray    = 1'($urandom);
      rDelay    = int'($urandom_range(0, 4));
      runTxn(rKind, rAddr, rData, rRegWrite, rReg, rBranch, rZero, rTarget,
             rDelay, rStray, rAck);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
